// File: rtl/piso_shift_tx_if.sv
// Load-side handshake and serial-side outputs of the PISO transmitter.
// The master drives words and the shift strobe; the slave (the transmitter) drives the serial stream.
interface piso_shift_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             busy;

    modport master (
        output load_data, load_valid, shift_en,
        input  load_ready, ser_out, ser_valid, ser_last, busy
    );

    modport slave (
        input  load_data, load_valid, shift_en,
        output load_ready, ser_out, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: shifts WIDTH-bit words out MSB first, one bit per shift_en,
// with a one-word holding buffer so consecutive words stream without an idle bit slot.
module piso_shift_tx #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    piso_shift_tx_if.slave io
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic load_ready;
    logic xfer;
    logic word_done;

    assign load_ready = !rst && !hold_full_q;
    assign xfer       = io.load_valid && load_ready;
    // Edge on which the final bit of the current word is consumed.
    assign word_done  = (state_q == SHIFT) && io.shift_en && (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    shreg_d = io.load_data;
                    cnt_d   = CNT_MAX;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (io.shift_en) begin
                    if (cnt_q != '0) begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q - 1'b1;
                    end else if (hold_full_q) begin
                        shreg_d     = hold_q;
                        cnt_d       = CNT_MAX;
                        hold_full_d = 1'b0;
                    end else if (xfer) begin
                        // Same-edge load bypasses the buffer to keep the stream gapless.
                        shreg_d = io.load_data;
                        cnt_d   = CNT_MAX;
                    end else begin
                        state_d = IDLE;
                    end
                end
                if (xfer && !word_done) begin
                    hold_d      = io.load_data;
                    hold_full_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign io.load_ready = load_ready;
    assign io.ser_valid  = (state_q == SHIFT);
    assign io.ser_out    = (state_q == SHIFT) && shreg_q[WIDTH-1];
    assign io.ser_last   = (state_q == SHIFT) && (cnt_q == '0);
    assign io.busy       = (state_q == SHIFT) || hold_full_q;
endmodule
